// File: rtl/poly_sub_stream_pkg.sv
// Shared Kyber constants and controller state encoding for the poly subtract stream.
package poly_sub_stream_pkg;
  localparam int KYBER_Q    = 3329;
  localparam int KYBER_N    = 256;
  localparam int COEF_W     = 12;
  localparam int POLY_ADDRW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;
endpackage

// File: rtl/poly_mod_diff.sv
// 3-stage modular subtract: y = (a - b) mod KYBER_Q, two guard bits internally.
module poly_mod_diff
  import poly_sub_stream_pkg::*;
#(
  parameter int WIDTH = COEF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  localparam int IW = WIDTH + 2;
  localparam logic signed [IW-1:0] Q = IW'(KYBER_Q);

  logic signed [IW-1:0] s1, s2;
  logic [WIDTH-1:0]     s3;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= $signed({2'b00, a}) - $signed({2'b00, b});
      s2 <= s1[IW-1] ? s1 + Q : s1;
      // only reachable for out-of-range operands; keeps the result bounded
      s3 <= (s2 >= Q) ? WIDTH'(s2 - Q) : WIDTH'(s2);
    end
  end

  assign y = s3;
endmodule

// File: rtl/poly_sub_stream.sv
// Streams NCOEF coefficient pairs through poly_mod_diff and writes (a - b) mod q back in order.
module poly_sub_stream
  import poly_sub_stream_pkg::*;
#(
  parameter int WIDTH = COEF_W,
  parameter int ADDRW = POLY_ADDRW,
  parameter int NCOEF = KYBER_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [ADDRW-1:0] rd_addr,
  input  logic [WIDTH-1:0] rd_a,
  input  logic [WIDTH-1:0] rd_b,
  output logic             wr_en,
  output logic [ADDRW-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data
);
  localparam int PIPE_LAT = 3;
  // vld_pipe[0] marks data arriving from the buffers; the top bit is the write strobe
  localparam int STAGES = PIPE_LAT + 1;
  localparam logic [ADDRW-1:0] LAST = ADDRW'(NCOEF - 1);

  state_t           state, state_nxt;
  logic [ADDRW-1:0] rd_cnt, wr_cnt;
  logic [STAGES:0]  vld_pipe;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] wr_data_q;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (rd_cnt == LAST) state_nxt = DRAIN;
      DRAIN:   if (wr_en && wr_cnt == LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_en = (state == ISSUE);
  assign busy  = (state != IDLE);
  assign done  = (state == FIN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      vld_pipe  <= '0;
      wr_data_q <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_en};
      if (rd_en)              rd_cnt    <= rd_cnt + ADDRW'(1);
      if (wr_en)              wr_cnt    <= wr_cnt + ADDRW'(1);
      if (vld_pipe[STAGES-1]) wr_data_q <= diff;
    end
  end

  poly_mod_diff #(.WIDTH(WIDTH)) u_diff (
    .clk (clk),
    .rst (rst),
    .a   (rd_a),
    .b   (rd_b),
    .y   (diff)
  );

  assign rd_addr = rd_cnt;
  assign wr_en   = vld_pipe[STAGES];
  assign wr_addr = wr_cnt;
  assign wr_data = wr_data_q;
endmodule

// File: tb/tb_poly_sub_stream.sv
// Directed bench for poly_sub_stream with buffer models, a write monitor and a golden mod-q model.
module tb_poly_sub_stream;
  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, rd_en, wr_en;
  logic [7:0]  rd_addr, wr_addr;
  logic [11:0] rd_a = '0, rd_b = '0, wr_data;

  logic [11:0] mem_a [256];
  logic [11:0] mem_b [256];
  logic [11:0] gold  [256];
  logic [11:0] cap   [256];

  int cyc = 0, cyc0 = 0, rel;
  int n_wr, n_done, first_wr, last_wr, done_cyc, ord_err, dat_err, busy_err;
  bit mon_on = 0, chk_busy = 1, inplace = 0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  poly_sub_stream dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // source buffers: one-cycle registered read; destination optionally aliased onto b
  always @(posedge clk) begin
    if (rd_en) begin
      rd_a <= mem_a[rd_addr];
      rd_b <= mem_b[rd_addr];
    end
    if (wr_en && inplace) mem_b[wr_addr] <= wr_data;
  end

  always @(negedge clk) if (mon_on) begin
    rel = cyc - cyc0;
    if (wr_en) begin
      if (n_wr == 0) first_wr = rel;
      last_wr = rel;
      if (wr_addr !== 8'(n_wr)) ord_err++;
      if (wr_data !== gold[wr_addr]) dat_err++;
      cap[wr_addr] = wr_data;
      n_wr++;
    end
    if (done === 1'b1) begin n_done++; done_cyc = rel; end
    if (chk_busy && busy !== (rel >= 1 && rel <= 262)) busy_err++;
  end

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 12'($urandom_range(0, 3328));
      mem_b[i] = 12'($urandom_range(0, 3328));
    end
  endtask

  task automatic begin_run();
    for (int i = 0; i < 256; i++) begin
      gold[i] = 12'((int'(mem_a[i]) - int'(mem_b[i]) + 3329) % 3329);
      cap[i]  = 'x;
    end
    n_wr = 0; n_done = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
    ord_err = 0; dat_err = 0; busy_err = 0;
    @(posedge clk); #1;
    cyc0 = cyc; start = 1'b1; mon_on = 1;
  endtask

  // advance to cycle n of the current run; start is pulsed in cycles s1/s2
  task automatic advance(input int n, input int s1, input int s2);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      start = (k == s1) || (k == s2);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if ({busy, done, rd_en, wr_en} !== 4'b0) begin errors++;
      $display("FAIL reset_strobes got=%b want=0000", {busy, done, rd_en, wr_en}); end
    checks++; if ({rd_addr, wr_addr, wr_data} !== 28'd0) begin errors++;
      $display("FAIL reset_addr_data got=%h want=0", {rd_addr, wr_addr, wr_data}); end
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if ({busy, rd_en, wr_en} !== 3'b0) begin errors++;
      $display("FAIL idle_after_reset got=%b want=000", {busy, rd_en, wr_en}); end
  endtask

  task automatic test_single_pair();
    for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    mem_a[0] = 12'd5; mem_b[0] = 12'd10;
    begin_run();
    advance(266, -1, -1);
    checks++; if (first_wr !== 6) begin errors++;
      $display("FAIL single_first_wr_cycle got=%0d want=6", first_wr); end
    checks++; if (cap[0] !== 12'd3324) begin errors++;
      $display("FAIL single_data got=%0d want=3324", cap[0]); end
    checks++; if (n_wr !== 256 || n_done !== 1 || done_cyc !== 262) begin errors++;
      $display("FAIL single_run_shape got wr=%0d done=%0d@%0d want 256,1@262", n_wr, n_done, done_cyc); end
  endtask

  task automatic test_boundaries();
    for (int i = 0; i < 256; i++) begin mem_a[i] = 12'(i); mem_b[i] = 12'(i); end
    mem_a[0] = 12'd1234; mem_b[0] = 12'd1234;
    mem_a[1] = 12'd3328; mem_b[1] = 12'd0;
    mem_a[2] = 12'd0;    mem_b[2] = 12'd3328;
    mem_a[3] = 12'd0;    mem_b[3] = 12'd0;
    begin_run();
    advance(266, -1, -1);
    checks++; if (cap[0] !== 12'd0) begin errors++; $display("FAIL bnd_equal got=%0d want=0", cap[0]); end
    checks++; if (cap[1] !== 12'd3328) begin errors++; $display("FAIL bnd_max_minus_zero got=%0d want=3328", cap[1]); end
    checks++; if (cap[2] !== 12'd1) begin errors++; $display("FAIL bnd_zero_minus_max got=%0d want=1", cap[2]); end
    checks++; if (cap[3] !== 12'd0) begin errors++; $display("FAIL bnd_zero got=%0d want=0", cap[3]); end
  endtask

  task automatic test_full_random();
    fill_random();
    begin_run();
    advance(268, -1, -1);
    checks++; if (n_wr !== 256) begin errors++; $display("FAIL full_wr_count got=%0d want=256", n_wr); end
    checks++; if (first_wr !== 6 || last_wr !== 261) begin errors++;
      $display("FAIL full_wr_window got=%0d..%0d want=6..261", first_wr, last_wr); end
    checks++; if (ord_err !== 0) begin errors++; $display("FAIL full_wr_order got=%0d bad want=0", ord_err); end
    checks++; if (dat_err !== 0) begin errors++; $display("FAIL full_data got=%0d bad want=0", dat_err); end
    checks++; if (n_done !== 1 || done_cyc !== 262) begin errors++;
      $display("FAIL full_done got=%0d@%0d want=1@262", n_done, done_cyc); end
    checks++; if (busy_err !== 0) begin errors++; $display("FAIL full_busy got=%0d bad cycles want=0", busy_err); end
  endtask

  task automatic test_start_ignored();
    fill_random();
    begin_run();
    advance(262, 50, 262);
    checks++; if (n_wr !== 256 || n_done !== 1 || done_cyc !== 262) begin errors++;
      $display("FAIL ign_run_shape got wr=%0d done=%0d@%0d want 256,1@262", n_wr, n_done, done_cyc); end
    checks++; if (dat_err !== 0 || ord_err !== 0) begin errors++;
      $display("FAIL ign_data got dat=%0d ord=%0d want=0,0", dat_err, ord_err); end
    fill_random();
    begin_run();
    advance(266, -1, -1);
    checks++; if (first_wr !== 6 || last_wr !== 261 || n_wr !== 256) begin errors++;
      $display("FAIL b2b_wr got=%0d..%0d n=%0d want=6..261 n=256", first_wr, last_wr, n_wr); end
    checks++; if (n_done !== 1 || done_cyc !== 262 || busy_err !== 0) begin errors++;
      $display("FAIL b2b_done got=%0d@%0d busyerr=%0d want=1@262,0", n_done, done_cyc, busy_err); end
    checks++; if (dat_err !== 0) begin errors++; $display("FAIL b2b_data got=%0d bad want=0", dat_err); end
  endtask

  task automatic test_mid_reset();
    fill_random();
    chk_busy = 0;
    begin_run();
    advance(99, -1, -1);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); #1;
    checks++; if ({busy, rd_en, wr_en, done} !== 4'b0) begin errors++;
      $display("FAIL midrst_strobes got=%b want=0000", {busy, rd_en, wr_en, done}); end
    checks++; if ({rd_addr, wr_addr} !== 16'd0) begin errors++;
      $display("FAIL midrst_addr got=%h want=0000", {rd_addr, wr_addr}); end
    n_wr = 0; n_done = 0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (n_wr !== 0 || n_done !== 0) begin errors++;
      $display("FAIL midrst_stale got wr=%0d done=%0d want=0,0", n_wr, n_done); end
    chk_busy = 1;
    begin_run();
    advance(266, -1, -1);
    checks++; if (n_wr !== 256 || first_wr !== 6 || ord_err !== 0 || dat_err !== 0) begin errors++;
      $display("FAIL midrst_rerun got n=%0d first=%0d ord=%0d dat=%0d want 256,6,0,0", n_wr, first_wr, ord_err, dat_err); end
    checks++; if (n_done !== 1 || done_cyc !== 262) begin errors++;
      $display("FAIL midrst_rerun_done got=%0d@%0d want=1@262", n_done, done_cyc); end
  endtask

  task automatic test_in_place();
    int bad;
    fill_random();
    inplace = 1;
    begin_run();
    advance(266, -1, -1);
    inplace = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem_b[i] !== gold[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL inplace_buffer got=%0d bad want=0", bad); end
    checks++; if (dat_err !== 0 || n_wr !== 256) begin errors++;
      $display("FAIL inplace_stream got dat=%0d n=%0d want=0,256", dat_err, n_wr); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_pair();
    test_boundaries();
    test_full_random();
    test_start_ignored();
    test_mid_reset();
    test_in_place();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/poly_sub_stream.md
Name: poly_sub_stream

Overview:
- Streaming controller that computes the coefficient-wise difference of two Kyber polynomials (q = 3329).
- Reads coefficient pairs from two polynomial buffers and pushes them through the existing 3-stage poly_mod_diff pipeline.
- Writes each reduced result back to a destination buffer.
- Sits between the polynomial RAMs and the modular subtract datapath; driven by the top-level sequencer through a start/done handshake.

Parameters:
- WIDTH, 12, coefficient width; fixed by q = 3329.
- ADDRW, 8, coefficient address width.
- NCOEF, 256, coefficients per polynomial; must equal 2**ADDRW.
- PIPE_LAT, 3, latency of poly_mod_diff in cycles; fixed constant, not user-tunable.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the done cycle, inclusive.
- done  out  1  one-cycle pulse when the last result has been written.
- rd_en  out  1  read strobe to both source buffers.
- rd_addr  out  ADDRW  coefficient index read.
- rd_a  in  WIDTH  minuend; valid the cycle after rd_en; must be < 3329.
- rd_b  in  WIDTH  subtrahend; same timing and range as rd_a.
- wr_en  out  1  write strobe to destination buffer.
- wr_addr  out  ADDRW  destination index.
- wr_data  out  WIDTH  (rd_a - rd_b) mod 3329, in [0, 3328].

Behaviour:
- Reset (rst = 0 at a clock edge): state IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0.
- Reset clears the read counter, write counter, valid shift register and the poly_mod_diff flops.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE -> ISSUE on start = 1. start in any other state is ignored; no queuing.
- ISSUE: rd_en = 1 every cycle, rd_addr = 0..NCOEF-1 incrementing by 1. Leave to DRAIN the cycle after rd_addr = NCOEF-1 is issued.
- DRAIN: rd_en = 0; wait until the write counter has completed NCOEF writes, then go to FIN.
- FIN: done = 1 for exactly one cycle, busy still 1; go to IDLE next cycle.
- Datapath timing, read issued at cycle t:
  - rd_a/rd_b arrive at t+1 and are fed unregistered to poly_mod_diff.
  - poly_mod_diff output is valid at t+4.
  - wr_en/wr_addr/wr_data are registered and appear at t+5.
  - Read-to-write latency is 5 cycles.
- Write tracking:
  - 5-deep valid shift register, fed by rd_en, generates wr_en.
  - wr_addr comes from a separate counter that increments on each write. Writes are strictly in order 0..NCOEF-1 with no gaps.
- Full-run timing, start at cycle 0:
  - reads at cycles 1..256;
  - writes at cycles 6..261;
  - done at cycle 262;
  - busy high at cycles 1..262;
  - start is accepted again from cycle 263.
- In-place operation is legal: the destination buffer may equal the b buffer, because each write trails its read of the same index by 5 cycles and indices are never revisited.
- Arithmetic: the result equals poly_mod_diff's output, with 14-bit internal width. For in-range inputs the result is exact mod 3329. Out-of-range inputs are a caller error; the output is unspecified but must not hang the FSM.
- No backpressure: buffers must accept one read and one write per cycle.
- Reset mid-run: the cycle after rst returns high, state is IDLE and all strobes are 0. No write from the aborted run may appear afterwards. A subsequent start runs normally from index 0.
- Counter wrap: the ADDRW-bit counters wrap naturally at NCOEF. Terminal detection uses an explicit last-index compare, not overflow.

Decomposition:
- Shared package holds:
  - KYBER_Q = 3329;
  - KYBER_N = 256;
  - COEF_W = 12;
  - POLY_ADDRW = 8;
  - the FSM state encoding (2-bit, localparams IDLE/ISSUE/DRAIN/FIN).
- One sub-module: the existing poly_mod_diff, instantiated unchanged with WIDTH = 12.
- Address counters, valid shift register and FSM live in this module.

Test Plan:
- Single pair: rd_a[0] = 5, rd_b[0] = 10 -> wr_data = 3324 at wr_addr 0, cycle 6 after start.
- Boundaries:
  - a = b = 1234 -> 0;
  - a = 3328, b = 0 -> 3328;
  - a = 0, b = 3328 -> 1;
  - a = 0, b = 0 -> 0.
- Full 256-coefficient random run vs golden model:
  - exactly 256 wr_en pulses at cycles 6..261, addresses 0..255 in order;
  - done only at cycle 262;
  - busy high at cycles 1..262.
- start pulsed at cycles 50 and 262 during a run -> ignored; exactly 256 writes; single done. Then start at 263 -> second full run with identical timing.
- rst = 0 at cycle 100 for one cycle:
  - the cycle after release: busy/rd_en/wr_en/done = 0 and addresses = 0;
  - no wr_en afterwards;
  - a new start yields a correct complete run.
- In-place run (destination aliased to b memory model) -> final buffer equals (a - b) mod 3329 for all 256 indices.
